// File: rtl/thresh_pkg.sv
// Shared types and helpers for the multi-channel timeout counter.
package thresh_pkg;

  // Per-channel FSM state; also exported by each channel for observation.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } thresh_state_t;

  // Width of the threshold-write channel address; never narrower than 1 bit.
  function automatic int THRESH_CH_W(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/thresh_channel.sv
// One timeout channel: IDLE/COUNT/EXPIRED FSM, tick counter and threshold compare.
// Strobes (start/ready/clear) are plain level-sampled controls, one decision per
// clock edge; there is no flow-control handshake on this block.
module thresh_channel
  import thresh_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             tick,
  input  logic             start,
  input  logic             ready,
  input  logic             clear,
  input  logic             rearm,
  input  logic [WIDTH-1:0] thresh,
  output thresh_state_t    state,
  output logic             timeout_pulse
);

  thresh_state_t    state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;

  // Next-state logic. In COUNT, ready beats start, and start beats expiry.
  // The >= compare keeps the counter at or below the threshold, so a lowered
  // threshold simply expires on the next tick and no wrap handling is needed.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COUNT;
          count_d = '0;
        end
      end
      COUNT: begin
        if (ready) begin
          state_d = IDLE;
          count_d = '0;
        end else if (start) begin
          count_d = '0;
        end else if (tick) begin
          if (count_q >= thresh) begin
            pulse_d = 1'b1;
            count_d = '0;
            if (!rearm) state_d = EXPIRED;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      EXPIRED: begin
        if (start) begin
          state_d = COUNT;
          count_d = '0;
        end else if (clear) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, counter and pulse registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

  assign state         = state_q;
  assign timeout_pulse = pulse_q;

endmodule

// File: rtl/multi_thresh_counter.sv
// Multi-channel programmable timeout counter: shared prescaler, threshold
// register file and one thresh_channel instance per channel.
module multi_thresh_counter
  import thresh_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 16,
  parameter int DEFAULT_THRESH = 1000,
  parameter int PRESCALE       = 1
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [CHANNELS-1:0]              start,
  input  logic [CHANNELS-1:0]              ready,
  input  logic [CHANNELS-1:0]              clear,
  input  logic [CHANNELS-1:0]              rearm,
  input  logic                             thresh_wr,
  input  logic [THRESH_CH_W(CHANNELS)-1:0] thresh_ch,
  input  logic [WIDTH-1:0]                 thresh_data,
  output logic [CHANNELS-1:0]              busy,
  output logic [CHANNELS-1:0]              expired,
  output logic [CHANNELS-1:0]              timeout_pulse,
  output logic                             any_expired
);

  logic             tick;
  logic [WIDTH-1:0] thresh_q [CHANNELS];
  logic [WIDTH-1:0] thresh_d [CHANNELS];
  thresh_state_t    ch_state [CHANNELS];

  if (PRESCALE > 1) begin : g_prescale
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0] pre_q, pre_d;

    // Free-running prescaler; wraps on the tick cycle.
    always_comb begin
      pre_d = (pre_q == PW'(PRESCALE - 1)) ? '0 : pre_q + PW'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) pre_q <= '0;
      else       pre_q <= pre_d;
    end

    assign tick = (pre_q == PW'(PRESCALE - 1));
  end else begin : g_no_prescale
    assign tick = 1'b1;
  end

  // Threshold write decode; addresses at or above CHANNELS match no entry.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      thresh_d[i] = thresh_q[i];
      if (thresh_wr && (int'(thresh_ch) == i)) thresh_d[i] = thresh_data;
    end
  end

  // Threshold register file, reset to the default threshold.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < CHANNELS; i++) thresh_q[i] <= WIDTH'(DEFAULT_THRESH);
    end else begin
      for (int i = 0; i < CHANNELS; i++) thresh_q[i] <= thresh_d[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    thresh_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clk          (clk),
      .rstN         (rstN),
      .tick         (tick),
      .start        (start[g]),
      .ready        (ready[g]),
      .clear        (clear[g]),
      .rearm        (rearm[g]),
      .thresh       (thresh_q[g]),
      .state        (ch_state[g]),
      .timeout_pulse(timeout_pulse[g])
    );

    assign busy[g]    = (ch_state[g] == COUNT);
    assign expired[g] = (ch_state[g] == EXPIRED);
  end

  assign any_expired = |expired;

endmodule
